imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 128, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 7, meaning word-address width, with 2**AW >= IMEM_DEPTH.
REQ-003 SHALL have parameter FILL_WORD, default 32'h00000063, meaning the value written to unloaded words (beq x0,x0,0).
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle load request
- len  in  8  number of words to load
- byte_valid  in  1  stream byte valid
- byte_data  in  8  stream byte, little-endian within each word
- byte_ready  out  1  byte accepted when byte_valid && byte_ready
- mem_we  out  1  IMEM write strobe, one cycle per word
- mem_waddr  out  AW  IMEM word address
- mem_wdata  out  32  IMEM write data
- busy  out  1  high in LOAD or FILL
- done  out  1  high in DONE
- err  out  1  high in ERR
- cpu_rst_n  out  1  CPU reset; low except in DONE

Function
REQ-006 The FSM SHALL have exactly five states: IDLE, LOAD, FILL, DONE, ERR.
REQ-007 From IDLE, DONE or ERR, start SHALL latch len and clear the counters. The next state SHALL be ERR if len > IMEM_DEPTH, FILL if len == 0, and LOAD otherwise.
REQ-008 start SHALL be ignored while in LOAD or FILL.
REQ-009 byte_ready SHALL be 1 in LOAD only until the 4*len-th byte is accepted, and 0 from that point and in every other state.
REQ-010 Accepted bytes SHALL be assembled LSB-first: byte k of a word goes to bits [8k+7:8k].
REQ-011 Acceptance of the 4th byte of a word SHALL copy the assembled word into a dedicated wdata register.
REQ-012 On the next cycle, mem_we=1, mem_waddr=word index and mem_wdata=that word; the word index SHALL then increment.
REQ-013 Write latency SHALL be exactly 1 cycle after the 4th byte is accepted.
REQ-014 Byte acceptance SHALL continue unstalled while a write is pending.
REQ-015 In the cycle that writes word len-1, the next state SHALL be FILL.
REQ-016 In FILL, mem_we SHALL be 1 every cycle, writing FILL_WORD to addresses len..IMEM_DEPTH-1 in ascending order.
REQ-017 After the write to IMEM_DEPTH-1, the next state SHALL be DONE. If len == IMEM_DEPTH, FILL SHALL last 0 cycles and go straight to DONE.
REQ-018 Bytes presented outside LOAD SHALL be ignored, with no writes.
REQ-019 In every cycle that is not a write, mem_we SHALL be 0.
REQ-020 cpu_rst_n SHALL be driven from a register and SHALL go high on the first cycle of DONE.
REQ-021 In ERR, no writes SHALL occur and cpu_rst_n SHALL stay 0.
REQ-022 mem_waddr SHALL never reach IMEM_DEPTH.

Reset
REQ-023 Assertion of rst_n low SHALL immediately force: state IDLE, byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst_n=0; byte counter, word counter and latched len SHALL clear.
REQ-024 Reset during LOAD or FILL SHALL abort with no further writes; a partial word SHALL be discarded.
REQ-025 Deassertion of rst_n SHALL take effect on the next rising edge of clk.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, LOAD, FILL, DONE, ERR), the default FILL_WORD constant and the default IMEM_DEPTH.
REQ-027 A single sub-module, imem_byte_packer, SHALL contain the 2-bit byte counter, the shift register and the word-complete pulse.
REQ-028 The FSM, counters and write port SHALL reside in imem_loader.

Verification
REQ-029 Reset, then start with len=2 and bytes 13,00,50,00,93,00,10,00 sent back-to-back:
- mem_we at words 0 and 1 with data 00500013 and 00100093, each 1 cycle after its 4th byte;
- then FILL writes 00000063 to addresses 2..127 (126 cycles);
- then done=1 and cpu_rst_n=1.
REQ-030 start with len=0: 128 consecutive FILL writes of 00000063 to addresses 0..127, then DONE.
REQ-031 start with len=200: ERR on the next cycle, err=1, no mem_we, cpu_rst_n=0. A following start with len=1 recovers to LOAD.
REQ-032 byte_valid toggled randomly with len=3: exactly 3 LOAD writes with correct data; byte_ready falls after the 12th accepted byte; extra bytes are ignored.
REQ-033 rst_n asserted after 6 bytes with len=4: outputs reach their reset values immediately, with no write after reset. A fresh start with len=1 then writes address 0 with the new word, not stale data.
REQ-034 start pulsed during FILL: ignored, and the FILL sequence and its end address are unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and defaults.
// Holds the FSM state encoding and the default memory geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    DONE,
    ERR
  } state_t;

  localparam int          IMEM_DEPTH_DEF = 128;
  localparam logic [31:0] FILL_WORD_DEF  = 32'h0000_0063;

endpackage

// File: rtl/imem_byte_packer.sv
// Byte-to-word packer for the IMEM loader.
// Assembles LSB-first bytes and flags the 4th byte of a word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        acc,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  // byte slot counter and right-shifting byte register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (clr) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (acc) begin
      cnt <= cnt + 2'd1;
      sr  <= {din, sr[23:8]};
    end
  end

  assign word      = {din, sr};
  assign word_done = acc && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into IMEM, pads the rest,
// then releases the CPU from reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int          AW         = 7,
  parameter logic [31:0] FILL_WORD  = FILL_WORD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_rst_n
);

  localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

  state_t        state, state_n;
  logic [7:0]    len_q;
  logic [9:0]    bcnt;
  logic [AW-1:0] widx;
  logic          wpend;
  logic [31:0]   wdata_q;
  logic          cpu_rst_q;

  logic          ld_go;
  logic          acc;
  logic          last_word;
  logic          full;
  logic          fill_last;
  logic [31:0]   word;
  logic          word_done;

  assign ld_go = start &&
    (state == IDLE || state == DONE || state == ERR);
  assign byte_ready = (state == LOAD) &&
    (bcnt != {len_q, 2'b00});
  assign acc = byte_valid && byte_ready;

  assign last_word = (32'(widx) == {24'd0, len_q} - 32'd1);
  assign full      = ({24'd0, len_q} == DEPTH);
  assign fill_last = (32'(widx) == DEPTH - 32'd1);

  imem_byte_packer u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ld_go),
    .acc       (acc),
    .din       (byte_data),
    .word      (word),
    .word_done (word_done)
  );

  // state register and registered CPU reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_rst_q <= 1'b0;
    end else begin
      state     <= state_n;
      cpu_rst_q <= (state_n == DONE);
    end
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          if ({24'd0, len} > DEPTH) state_n = ERR;
          else if (len == 8'd0)     state_n = FILL;
          else                      state_n = LOAD;
        end
      end
      LOAD: begin
        if (wpend && last_word)
          state_n = full ? DONE : FILL;
      end
      FILL: begin
        if (fill_last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // counters, latched length and write-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= 8'd0;
      bcnt    <= 10'd0;
      widx    <= '0;
      wpend   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      wpend <= 1'b0;
      if (ld_go) begin
        len_q <= len;
        bcnt  <= 10'd0;
        widx  <= '0;
      end else begin
        if (acc) bcnt <= bcnt + 10'd1;
        if (word_done) begin
          wpend   <= 1'b1;
          wdata_q <= word;
        end
        if (state == LOAD && wpend) begin
          if (!last_word)
            widx <= widx + 1'b1;
          else if (!full)
            widx <= AW'(len_q);
        end
        if (state == FILL && !fill_last)
          widx <= widx + 1'b1;
      end
    end
  end

  assign mem_we    = wpend || (state == FILL);
  assign mem_waddr = widx;
  assign mem_wdata = (state == FILL) ? FILL_WORD : wdata_q;
  assign busy      = (state == LOAD) || (state == FILL);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign cpu_rst_n = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Logs writes/handshakes at negedge, checks against hand values.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  int n_tests;
  int n_fail;
  int cyc;

  int          w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          a_cyc[$];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_rst_n  (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      w_addr.push_back(int'(mem_waddr));
      w_data.push_back(mem_wdata);
      w_cyc.push_back(cyc);
    end
    if (byte_valid && byte_ready)
      a_cyc.push_back(cyc);
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    a_cyc.delete();
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      tick();
    end
  endtask

  task automatic chk_fill(string tag, int idx, int addr);
    int bad;
    bad = 0;
    for (int i = idx; i < w_addr.size(); i++) begin
      if (w_addr[i] != addr + (i - idx)) bad++;
      if (w_data[i] !== 32'h0000_0063) bad++;
      if (i > idx && w_cyc[i] != w_cyc[i-1] + 1) bad++;
    end
    chk({tag, "_fill_bad"}, 32'(bad), 32'd0);
    chk({tag, "_nwr"}, 32'(w_addr.size() - idx),
        32'(128 - addr));
  endtask

  logic [31:0] pat [3];
  logic [7:0]  b;
  logic        v;
  logic        r;
  int          idx;
  int          nbefore;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = 8'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    pat[0] = 32'h1122_3344;
    pat[1] = 32'ha5a5_5a5a;
    pat[2] = 32'h0000_0013;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {26'd0, byte_ready, mem_we, busy,
        done, err, cpu_rst_n}, 32'd0);
    chk("rst_addr", 32'(mem_waddr), 32'd0);
    chk("rst_data", mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // len=2 boot image
    clr_log();
    do_start(8'd2);
    chk("t1_ready", 32'(byte_ready), 32'd1);
    send(8'h13); send(8'h00); send(8'h50); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    wait_done();
    #4;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpurst", 32'(cpu_rst_n), 32'd1);
    chk("t1_nacc", 32'(a_cyc.size()), 32'd8);
    if (w_addr.size() >= 2 && a_cyc.size() >= 8) begin
      chk("t1_a0", 32'(w_addr[0]), 32'd0);
      chk("t1_d0", w_data[0], 32'h0050_0013);
      chk("t1_lat0", 32'(w_cyc[0]), 32'(a_cyc[3] + 1));
      chk("t1_a1", 32'(w_addr[1]), 32'd1);
      chk("t1_d1", w_data[1], 32'h0010_0093);
      chk("t1_lat1", 32'(w_cyc[1]), 32'(a_cyc[7] + 1));
      if (w_addr.size() > 2)
        chk("t1_gap", 32'(w_cyc[2]), 32'(w_cyc[1] + 1));
      else
        chk("t1_gap", 32'(w_addr.size()), 32'd3);
      chk_fill("t1", 2, 2);
    end else begin
      chk("t1_nwr", 32'(w_addr.size()), 32'd128);
    end
    tick();

    // len=0: pure fill
    clr_log();
    do_start(8'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_cpurst", 32'(cpu_rst_n), 32'd0);
    wait_done();
    #4;
    chk("t2_done", 32'(done), 32'd1);
    chk_fill("t2", 0, 0);
    tick();

    // len=200: error, bytes ignored, then recovery
    clr_log();
    do_start(8'd200);
    chk("t3_err", {29'd0, err, busy, cpu_rst_n}, 32'd4);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (4) tick();
    chk("t3_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    chk("t3_nwr", 32'(w_addr.size()), 32'd0);
    do_start(8'd1);
    chk("t3_load", {30'd0, busy, byte_ready}, 32'd3);
    send(8'hef); send(8'hbe); send(8'had); send(8'hde);
    wait_done();
    #4;
    chk("t3_done", 32'(done), 32'd1);
    if (w_addr.size() > 0) begin
      chk("t3_a0", 32'(w_addr[0]), 32'd0);
      chk("t3_d0", w_data[0], 32'hdead_beef);
    end
    chk_fill("t3", 1, 1);
    tick();

    // len=3 with random valid gaps and trailing extra bytes
    clr_log();
    do_start(8'd3);
    idx = 0;
    for (int i = 0; i < 300 && idx < 12; i++) begin
      v = 1'($urandom_range(0, 1));
      b = 8'(pat[idx / 4] >> (8 * (idx % 4)));
      byte_valid = v;
      byte_data  = b;
      r = byte_ready;
      tick();
      if (v && r) idx++;
    end
    byte_valid = 1'b0;
    chk("t4_nbytes", 32'(idx), 32'd12);
    chk("t4_ready_low", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'hcc;
    repeat (5) tick();
    byte_valid = 1'b0;
    wait_done();
    #4;
    chk("t4_nacc", 32'(a_cyc.size()), 32'd12);
    if (w_addr.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t4_a%0d", k), 32'(w_addr[k]), 32'(k));
        chk($sformatf("t4_d%0d", k), w_data[k], pat[k]);
      end
    end
    chk_fill("t4", 3, 3);
    tick();

    // reset mid-load after 6 bytes, then a fresh load
    clr_log();
    do_start(8'd4);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06);
    nbefore = w_addr.size();
    chk("t5_prewr", 32'(nbefore), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctl", {26'd0, byte_ready, mem_we, busy,
        done, err, cpu_rst_n}, 32'd0);
    chk("t5_rst_addr", 32'(mem_waddr), 32'd0);
    chk("t5_rst_data", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_log();
    repeat (3) tick();
    chk("t5_nowr", 32'(w_addr.size()), 32'd0);
    do_start(8'd1);
    send(8'hfe); send(8'hca); send(8'had); send(8'h0b);
    wait_done();
    #4;
    if (w_addr.size() > 0) begin
      chk("t5_a0", 32'(w_addr[0]), 32'd0);
      chk("t5_d0", w_data[0], 32'h0bad_cafe);
    end
    chk_fill("t5", 1, 1);
    tick();

    // start pulsed during FILL is ignored
    clr_log();
    do_start(8'd0);
    repeat (10) tick();
    do_start(8'd5);
    chk("t6_busy", {30'd0, busy, err}, 32'd2);
    wait_done();
    #4;
    chk("t6_done", 32'(done), 32'd1);
    chk_fill("t6", 0, 0);
    if (w_addr.size() > 0)
      chk("t6_last", 32'(w_addr[w_addr.size() - 1]), 32'd127);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
